instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 redirect_i  input  1  branch/jump taken; load redirect_pc_i into PC.
REQ-005 redirect_pc_i  input  32  redirect target; bits [1:0] forced to 00.
REQ-006 imem_req_o  output  1  instruction-memory read request, registered.
REQ-007 imem_addr_o  output  32  read address, equal to PC; stable while imem_req_o=1 and no ack.
REQ-008 imem_ack_i  input  1  one-cycle pulse; imem_data_i valid this cycle.
REQ-009 imem_data_i  input  32  fetched instruction word.
REQ-010 id_valid_o  output  1  decode-stage instruction valid.
REQ-011 id_ready_i  input  1  decode stage accepts instruction this cycle.
REQ-012 id_instr_o  output  32  latched instruction.
REQ-013 id_pc4_o  output  32  address of latched instruction plus 4.
REQ-014 id_imm_o  output  16  id_instr_o[15:0]; immediate field for the sign/zero extenders.

Function
REQ-015 Three states: S_FETCH (request outstanding), S_HOLD (instruction held for decode), S_DROP (discard an in-flight response after redirect).
REQ-016 imem_req_o shall be 1 exactly in S_FETCH and S_DROP; 0 in S_HOLD.
REQ-017 S_FETCH, ack=1, redirect=0: latch imem_data_i into id_instr_o, id_pc4_o<=PC+4, PC<=PC+4, id_valid_o<=1, go S_HOLD.
REQ-018 S_FETCH, redirect=1, ack=1 same cycle: discard data, PC<=redirect_pc_i, stay S_FETCH at new address next cycle.
REQ-019 S_FETCH, redirect=1, ack=0: PC<=redirect_pc_i, go S_DROP; imem_addr_o keeps the old address until ack.
REQ-020 S_DROP: ack=1 discards data and goes S_FETCH at PC; redirect in S_DROP updates PC again, remains S_DROP until ack.
REQ-021 S_HOLD: redirect=1 clears id_valid_o, PC<=redirect_pc_i, go S_FETCH; redirect has priority over id_ready_i.
REQ-022 S_HOLD: id_valid_o=1 and id_ready_i=1, no redirect: id_valid_o<=0, go S_FETCH.
REQ-023 S_HOLD, id_ready_i=0: id_instr_o, id_pc4_o, id_valid_o held unchanged.
REQ-024 PC arithmetic 32-bit unsigned, wraps modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-025 Minimum latency: ack to id_valid_o=1 is one cycle; peak throughput one instruction per two cycles.
REQ-026 imem_ack_i in S_HOLD is ignored.

Reset
REQ-027 When rst_i=1 at a clock edge: PC<=RESET_PC, state<=S_FETCH, imem_req_o<=0, id_valid_o<=0, id_instr_o<=0, id_pc4_o<=0; rst_i has priority over redirect_i and imem_ack_i.
REQ-028 First cycle after reset release: imem_req_o=1, imem_addr_o=RESET_PC.
REQ-029 Reset mid-request abandons it; instruction memory is reset by the same rst_i, so no stale ack arrives.

Structure
REQ-030 Shared package holds the state encoding (2-bit), RESET_PC default and the PC increment constant 4.
REQ-031 One sub-module: Adder (32-bit PC+4), reusing the existing CPU adder.

Verification
REQ-032 Reset, then ack with 32'h2001_0005 one cycle after request -> id_valid_o=1, id_instr_o=32'h2001_0005, id_imm_o=16'h0005, id_pc4_o=4.
REQ-033 id_ready_i=0 for 3 cycles in S_HOLD -> outputs stable, imem_req_o=0; ready=1 -> next request at 32'h4.
REQ-034 Redirect to 32'h0000_0103 with no ack -> imem_addr_o stays old; next ack discarded; following request address 32'h0000_0100.
REQ-035 Redirect and ack same cycle -> no id_valid_o; next cycle imem_addr_o=redirect target.
REQ-036 RESET_PC=32'hFFFF_FFFC, one ack -> id_pc4_o=0, next imem_addr_o=0.
REQ-037 rst_i asserted in S_HOLD with id_ready_i=0 -> id_valid_o=0 next cycle; request at RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared state encoding, reset PC default and PC increment
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
endpackage

// File: rtl/instr_fetch_unit_adder.sv
// instr_fetch_unit_adder: W-bit unsigned adder, wraps modulo 2^W
// Ports: a, b operands; y = a + b
module instr_fetch_unit_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words and holds one for the decode stage
// Ports: clk_i/rst_i clock and sync reset; redirect_i/redirect_pc_i branch target;
// imem_req_o/imem_addr_o/imem_ack_i/imem_data_i memory read; id_* decode handshake and payload
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc4_o,
  output logic [15:0] id_imm_o
);
  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc_plus4, redir_pc;
  logic        ack, take;

  instr_fetch_unit_adder #(.W(32)) u_adder (
    .a(pc),
    .b(PC_INC),
    .y(pc_plus4)
  );

  // An ack only counts against a request actually on the bus (none right after reset)
  always_comb begin
    ack        = imem_ack_i & imem_req_o;
    redir_pc   = {redirect_pc_i[31:2], 2'b00};
    take       = (state == S_FETCH) & ack & ~redirect_i;
    pc_next    = redirect_i ? redir_pc : take ? pc_plus4 : pc;
    state_next = state;
    if (state == S_FETCH)
      state_next = redirect_i ? ((imem_req_o & ~ack) ? S_DROP : S_FETCH) : (ack ? S_HOLD : S_FETCH);
    else if (state == S_DROP)
      state_next = ack ? S_FETCH : S_DROP;
    else
      state_next = (redirect_i | id_ready_i) ? S_FETCH : S_HOLD;
  end

  // The bus address only moves once the outstanding request is answered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
      id_valid_o  <= 1'b0;
      id_instr_o  <= '0;
      id_pc4_o    <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      imem_req_o <= state_next != S_HOLD;
      if (!(imem_req_o && !ack)) imem_addr_o <= pc_next;
      if (take) begin
        id_instr_o <= imem_data_i;
        id_pc4_o   <= pc_plus4;
      end
      id_valid_o <= take | ((state == S_HOLD) & ~redirect_i & ~id_ready_i);
    end
  end

  assign id_imm_o = id_instr_o[15:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven directed checks of instr_fetch_unit
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, redirect, ack, ready;
  logic [31:0] redirect_pc, data;
  logic        req, valid;
  logic [31:0] addr, instr, pc4;
  logic [15:0] imm;
  logic        ack2, ready2;
  logic [31:0] data2;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc42;
  logic [15:0] imm2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .id_valid_o(valid), .id_ready_i(ready), .id_instr_o(instr), .id_pc4_o(pc4), .id_imm_o(imm)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_data_i(data2),
    .id_valid_o(valid2), .id_ready_i(ready2), .id_instr_o(instr2), .id_pc4_o(pc42), .id_imm_o(imm2)
  );

  typedef struct {
    logic        rst, rd;
    logic [31:0] rd_pc;
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc4;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic r, logic rd, logic [31:0] rp, logic a, logic [31:0] d, logic y,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ei, logic [31:0] ep);
    vec_t t;
    t.rst = r; t.rd = rd; t.rd_pc = rp; t.ack = a; t.data = d; t.rdy = y;
    t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_instr = ei; t.e_pc4 = ep;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //              rst rd  rd_pc          ack data           rdy  req addr           vld instr          pc4
    tbl[0]  = mk(1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,          0, 32'h0,         32'h0);
    tbl[1]  = mk(0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,          0, 32'h0,         32'h0);
    tbl[2]  = mk(0, 0, 32'h0,         1, 32'h2001_0005, 0,   0, 32'h4,          1, 32'h2001_0005, 32'h4);
    tbl[3]  = mk(0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h4,          1, 32'h2001_0005, 32'h4);
    tbl[4]  = mk(0, 0, 32'h0,         1, 32'hDEAD_BEEF, 0,   0, 32'h4,          1, 32'h2001_0005, 32'h4);
    tbl[5]  = mk(0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h4,          1, 32'h2001_0005, 32'h4);
    tbl[6]  = mk(0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h4,          0, 32'h2001_0005, 32'h4);
    tbl[7]  = mk(0, 1, 32'h103,       0, 32'h0,         1,   1, 32'h4,          0, 32'h2001_0005, 32'h4);
    tbl[8]  = mk(0, 0, 32'h0,         0, 32'h0,         1,   1, 32'h4,          0, 32'h2001_0005, 32'h4);
    tbl[9]  = mk(0, 0, 32'h0,         1, 32'h1111_1111, 1,   1, 32'h100,        0, 32'h2001_0005, 32'h4);
    tbl[10] = mk(0, 1, 32'h200,       1, 32'h2222_2222, 1,   1, 32'h200,        0, 32'h2001_0005, 32'h4);
    tbl[11] = mk(0, 0, 32'h0,         1, 32'h3333_3333, 0,   0, 32'h204,        1, 32'h3333_3333, 32'h204);
    tbl[12] = mk(0, 1, 32'h300,       0, 32'h0,         1,   1, 32'h300,        0, 32'h3333_3333, 32'h204);
    tbl[13] = mk(0, 1, 32'h400,       0, 32'h0,         1,   1, 32'h300,        0, 32'h3333_3333, 32'h204);
    tbl[14] = mk(0, 1, 32'h502,       0, 32'h0,         1,   1, 32'h300,        0, 32'h3333_3333, 32'h204);
    tbl[15] = mk(0, 0, 32'h0,         1, 32'h5555_5555, 1,   1, 32'h500,        0, 32'h3333_3333, 32'h204);
    tbl[16] = mk(0, 0, 32'h0,         1, 32'h4444_4444, 0,   0, 32'h504,        1, 32'h4444_4444, 32'h504);
    tbl[17] = mk(1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,          0, 32'h0,         32'h0);
    tbl[18] = mk(0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,          0, 32'h0,         32'h0);
    tbl[19] = mk(0, 0, 32'h0,         1, 32'hAAAA_8001, 0,   0, 32'h4,          1, 32'hAAAA_8001, 32'h4);
    tbl[20] = mk(1, 1, 32'h700,       1, 32'h6666_6666, 0,   0, 32'h0,          0, 32'h0,         32'h0);
    tbl[21] = mk(0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,          0, 32'h0,         32'h0);
    ack2 = 1'b0; ready2 = 1'b0; data2 = 32'h0;
    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; redirect = tbl[i].rd; redirect_pc = tbl[i].rd_pc;
      ack = tbl[i].ack; data = tbl[i].data; ready = tbl[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("v%0d req", i),   {31'b0, req},   {31'b0, tbl[i].e_req});
      chk($sformatf("v%0d addr", i),  addr,           tbl[i].e_addr);
      chk($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("v%0d instr", i), instr,          tbl[i].e_instr);
      chk($sformatf("v%0d pc4", i),   pc4,            tbl[i].e_pc4);
      chk($sformatf("v%0d imm", i),   {16'b0, imm},   {16'b0, tbl[i].e_instr[15:0]});
    end
    // Wrap-around of the PC at the top of the address space
    chk("wrap req0",  {31'b0, req2}, 32'd1);
    chk("wrap addr0", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1; data2 = 32'h1234_5678;
    @(posedge clk); #1;
    ack2 = 1'b0;
    chk("wrap valid", {31'b0, valid2}, 32'd1);
    chk("wrap instr", instr2, 32'h1234_5678);
    chk("wrap pc4",   pc42, 32'h0);
    chk("wrap imm",   {16'b0, imm2}, 32'h5678);
    chk("wrap req1",  {31'b0, req2}, 32'd0);
    ready2 = 1'b1;
    @(posedge clk); #1;
    chk("wrap req2",  {31'b0, req2}, 32'd1);
    chk("wrap addr2", addr2, 32'h0);
    chk("wrap valid2", {31'b0, valid2}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
